// File: rtl/lsu_bus.sv
// rtl/lsu_bus.sv - load/store unit bridging ex-stage memory requests onto a req/gnt/rvalid bus
module lsu_bus #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_wr_addr,
  input  logic [31:0] mem_wr_data,
  input  logic        mem_rd_req,
  input  logic [31:0] mem_rd_addr,
  output logic [31:0] mem_rd_data,
  output logic        hold_flag_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, RWAIT, DONE} state_t;

  state_t      state;
  logic [7:0]  tmo_cnt;
  logic [31:0] rd_data;
  logic        store_req;
  logic        load_req;
  logic        any_req;
  logic        tmo_hit;
  logic        unused_addr_lsbs;

  // A store outranks a simultaneous load; the load is simply dropped.
  assign store_req = |mem_wen;
  assign load_req  = mem_rd_req & ~store_req;
  assign any_req   = store_req | load_req;
  assign tmo_hit   = (tmo_cnt == 8'(TIMEOUT - 1));

  assign unused_addr_lsbs = ^{mem_wr_addr[1:0], mem_rd_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      rd_data     <= '0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_be_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state       <= REQ;
            tmo_cnt     <= '0;
            bus_we_o    <= store_req;
            bus_addr_o  <= store_req ? {mem_wr_addr[31:2], 2'b00} : {mem_rd_addr[31:2], 2'b00};
            bus_wdata_o <= store_req ? mem_wr_data : '0;
            bus_be_o    <= store_req ? mem_wen : 4'hF;
          end
        end
        REQ: begin
          // A grant in the timeout cycle still counts as success.
          if (bus_gnt_i) begin
            state   <= bus_we_o ? DONE : RWAIT;
            tmo_cnt <= '0;
          end else if (tmo_hit) begin
            state   <= DONE;
            rd_data <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        RWAIT: begin
          if (bus_rvalid_i) begin
            state   <= DONE;
            rd_data <= bus_rdata_i;
          end else if (tmo_hit) begin
            state   <= DONE;
            rd_data <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Hold rises combinationally in IDLE so the requesting instruction stalls at once.
  assign hold_flag_o = (state == IDLE) ? any_req : ((state == REQ) || (state == RWAIT));
  assign bus_req_o   = (state == REQ);
  assign bus_err_o   = tmo_hit && (((state == REQ) && !bus_gnt_i) ||
                                   ((state == RWAIT) && !bus_rvalid_i));
  assign mem_rd_data = rd_data;

endmodule

// File: tb/tb_lsu_bus.sv
// tb/tb_lsu_bus.sv - scoreboard bench for lsu_bus against a cycle-schedule reference model
module tb_lsu_bus;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  mem_wen = '0;
  logic [31:0] mem_wr_addr = '0;
  logic [31:0] mem_wr_data = '0;
  logic        mem_rd_req = 1'b0;
  logic [31:0] mem_rd_addr = '0;
  logic [31:0] mem_rd_data;
  logic        hold_flag_o;
  logic        bus_err_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i = 1'b0;
  logic        bus_rvalid_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;

  lsu_bus #(.TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .mem_wen(mem_wen), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .hold_flag_o(hold_flag_o), .bus_err_o(bus_err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          c0;
    int          d;
    int          nerr;
    int          nreq;
    logic [31:0] rd;
  } exp_t;

  exp_t start_q[$];
  exp_t bus_q[$];
  exp_t done_q[$];

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] drv_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mem_wen = '0; mem_rd_req = 1'b0;
      mem_wr_addr = '0; mem_wr_data = '0; mem_rd_addr = '0;
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = $urandom;
    end
  endtask

  // One request: g = REQ cycles waited before gnt, r = RWAIT cycles before rvalid;
  // a value >= T means the bus never answers in time.
  task automatic txn(input logic [3:0] wen, input logic rd_req,
                     input logic [31:0] waddr, input logic [31:0] wdata,
                     input logic [31:0] raddr, input logic [31:0] rdata,
                     input int g, input int r, input bit spur);
    exp_t e;
    bit   st;
    int   c0;
    int   req_last;
    st = (wen != 4'h0);
    @(negedge clk);
    c0 = cyc;
    e.we    = st;
    e.addr  = (st ? waddr : raddr) & 32'hFFFF_FFFC;
    e.wdata = wdata;
    e.be    = st ? wen : 4'hF;
    e.c0    = c0;
    e.nreq  = (g < T) ? g + 1 : T;
    if (g >= T)      begin e.d = c0 + 1 + T;     e.nerr = 1; end
    else if (st)     begin e.d = c0 + 2 + g;     e.nerr = 0; end
    else if (r >= T) begin e.d = c0 + 2 + g + T; e.nerr = 1; end
    else             begin e.d = c0 + 3 + g + r; e.nerr = 0; end
    if (e.nerr != 0) e.rd = '0;
    else if (st)     e.rd = drv_rd;
    else             e.rd = rdata;
    drv_rd = e.rd;
    start_q.push_back(e);
    bus_q.push_back(e);
    done_q.push_back(e);
    req_last = (g < T) ? c0 + 1 + g : c0 + T;
    mem_wen = wen; mem_rd_req = rd_req;
    mem_wr_addr = waddr; mem_wr_data = wdata; mem_rd_addr = raddr;
    for (int k = c0; k <= e.d; k++) begin
      if (k != c0) @(negedge clk);
      bus_gnt_i    = (g < T) && (k == c0 + 1 + g);
      bus_rvalid_i = 1'b0;
      bus_rdata_i  = $urandom;
      if (!st && g < T && r < T && k == c0 + 2 + g + r) begin
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = rdata;
      end else if (spur && ((k >= c0 + 1 && k <= req_last) || k == e.d) &&
                   $urandom_range(0, 1) == 1) begin
        bus_rvalid_i = 1'b1;
      end
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rd_data"}, mem_rd_data, 32'h0);
    chk({tag, "_hold"}, {31'h0, hold_flag_o}, 32'h0);
    chk({tag, "_err"}, {31'h0, bus_err_o}, 32'h0);
    chk({tag, "_req"}, {31'h0, bus_req_o}, 32'h0);
    chk({tag, "_we"}, {31'h0, bus_we_o}, 32'h0);
    chk({tag, "_addr"}, bus_addr_o, 32'h0);
    chk({tag, "_wdata"}, bus_wdata_o, 32'h0);
    chk({tag, "_be"}, {28'h0, bus_be_o}, 32'h0);
  endtask

  // Monitor: pops expectations when the DUT shows a request start, a bus request or completion.
  initial begin
    exp_t e;
    logic        prev_hold;
    logic        prev_req;
    int          err_cnt;
    int          req_cnt;
    logic [31:0] rd_model;
    prev_hold = 1'b0; prev_req = 1'b0; err_cnt = 0; req_cnt = 0; rd_model = '0;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        prev_hold = 1'b0; prev_req = 1'b0; err_cnt = 0; req_cnt = 0; rd_model = '0;
        continue;
      end
      if (bus_err_o) err_cnt++;
      if (bus_req_o) req_cnt++;
      if (hold_flag_o && !prev_hold) begin
        chk("start_expected", {31'h0, start_q.size() != 0}, 32'h1);
        if (start_q.size() != 0) begin
          e = start_q.pop_front();
          chk("start_cycle", cyc, e.c0);
        end
      end
      if (bus_req_o && !prev_req) begin
        chk("bus_req_expected", {31'h0, bus_q.size() != 0}, 32'h1);
        if (bus_q.size() != 0) begin
          e = bus_q.pop_front();
          chk("req_cycle", cyc, e.c0 + 1);
          chk("bus_we", {31'h0, bus_we_o}, {31'h0, e.we});
          chk("bus_addr", bus_addr_o, e.addr);
          chk("bus_be", {28'h0, bus_be_o}, {28'h0, e.be});
          if (e.we) chk("bus_wdata", bus_wdata_o, e.wdata);
        end
      end
      if (!hold_flag_o && prev_hold) begin
        chk("done_expected", {31'h0, done_q.size() != 0}, 32'h1);
        if (done_q.size() != 0) begin
          e = done_q.pop_front();
          chk("done_cycle", cyc, e.d);
          chk("done_rd_data", mem_rd_data, e.rd);
          chk("err_pulses", err_cnt, e.nerr);
          chk("req_cycles", req_cnt, e.nreq);
          rd_model = e.rd;
        end
        err_cnt = 0;
        req_cnt = 0;
      end else begin
        chk("rd_data_held", mem_rd_data, rd_model);
      end
      prev_hold = hold_flag_o;
      prev_req  = bus_req_o;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] wen;
    logic       rdq;
    int         g;
    int         r;
    repeat (2) @(negedge clk);
    #1 chk_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    txn(4'hF, 1'b0, 32'h104, 32'hDEADBEEF, 32'h0, 32'h0, 0, 0, 1'b0);
    txn(4'h0, 1'b1, 32'h0, 32'h0, 32'h20, 32'h12345678, 3, 1, 1'b0);
    txn(4'b0100, 1'b1, 32'h202, 32'h00AB0000, 32'h300, 32'hCAFEF00D, 1, 0, 1'b0);
    idle(1);
    txn(4'h0, 1'b1, 32'h0, 32'h0, 32'h40, 32'h55AA55AA, T, 0, 1'b0);
    txn(4'h0, 1'b1, 32'h0, 32'h0, 32'h44, 32'h0BADF00D, T - 1, T - 1, 1'b1);
    txn(4'h0, 1'b1, 32'h0, 32'h0, 32'h48, 32'h77777777, 0, T, 1'b1);
    txn(4'h0, 1'b1, 32'h0, 32'h0, 32'h4C, 32'h99999999, 1, 0, 1'b0);

    // Reset while waiting for read data.
    begin
      exp_t e;
      @(negedge clk);
      e.we = 1'b0; e.addr = 32'h80; e.wdata = '0; e.be = 4'hF;
      e.c0 = cyc; e.d = 0; e.nerr = 0; e.nreq = 1; e.rd = '0;
      start_q.push_back(e);
      bus_q.push_back(e);
      mem_rd_req = 1'b1; mem_rd_addr = 32'h83;
      @(negedge clk);
      bus_gnt_i = 1'b1;
      @(negedge clk);
      bus_gnt_i = 1'b0;
      #1;
      rst = 1'b1;
      mem_rd_req = 1'b0; mem_rd_addr = '0;
      #1 chk_outputs_zero("midreset");
      @(negedge clk);
      #1 chk_outputs_zero("midreset_held");
      @(negedge clk);
      rst = 1'b0;
      drv_rd = '0;
    end
    txn(4'b0011, 1'b0, 32'h500, 32'h0000BEEF, 32'h0, 32'h0, 1, 0, 1'b0);

    txn(4'h0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h11, 0, 0, 1'b0);
    txn(4'h0, 1'b1, 32'h0, 32'h0, 32'h4, 32'h22, 0, 0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      wen = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      rdq = (wen == 4'h0) ? 1'b1 : 1'($urandom);
      g = $urandom_range(0, T);
      r = $urandom_range(0, T);
      txn(wen, rdq, $urandom, $urandom, $urandom, $urandom, g, r, 1'($urandom));
      idle($urandom_range(0, 2));
    end
    idle(4);
    chk("start_q_drained", start_q.size(), 0);
    chk("bus_q_drained", bus_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
